// File: rtl/arb_fifo_scoreboard.sv
// ---------------------------------------------------------------------------
// arb_fifo_scoreboard
//
// Monitors NUM_REQS FIFO channels that share one arbitrated output. The
// block keeps a shadow occupancy count for every channel. On request it
// follows one pushed item through its channel and checks that the item
// leaves the shared output with the same data it entered with.
//
// Flow: start (in IDLE/DONE) arms the block on channel `sel`. The next
// accepted push on that channel is captured together with its queue
// position. Every accepted pop on the channel moves the item one place
// closer to the head. The pop that removes the item compares data_out
// against the captured value. A non-zero timeout_lim bounds the time
// spent waiting for that pop.
//
// Handshake semantics: push[i]/pop[i] are single-cycle strobes with no
// back-pressure. A push counts only when channel i has room, or when a
// pop on the same channel is accepted in the same cycle. A pop counts
// only when channel i is non-empty. Anything that is not accepted is
// dropped silently.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous active-low reset
//   start         in   arm request (honoured in IDLE/DONE only)
//   sel           in   channel to track, sampled on an accepted start
//   push/pop      in   per-channel strobes
//   flat_data_in  in   per-channel push data, channel i at [i*WIDTH +: WIDTH]
//   data_out      in   shared FIFO output, valid in any cycle with a pop
//   timeout_lim   in   TRACK cycle budget, 0 = unlimited
//   busy          out  ARMED or TRACK
//   done          out  DONE
//   prop_signal   out  low only after a detected failure
//   timeout       out  failure was a timeout
//   tracked_sel   out  latched channel
//   dbg_state_o   out  FSM state (IDLE=0, ARMED=1, TRACK=2, DONE=3)
//   dbg_pos_o     out  position of the tracked item (0 = head)
//   dbg_wait_o    out  TRACK wait counter
//   dbg_cnt_o     out  packed occupancy counts, channel i at [i*CNTW +: CNTW]
// ---------------------------------------------------------------------------
module arb_fifo_scoreboard #(
   parameter  int NUM_REQS = 4,
   parameter  int WIDTH    = 8,
   parameter  int DEPTH    = 8,
   parameter  int TWID     = 8,
   localparam int SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
   localparam int CNTW     = $clog2(DEPTH + 1),
   localparam int PTRW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [SELW-1:0]          sel,
   input  logic [NUM_REQS-1:0]      push,
   input  logic [NUM_REQS-1:0]      pop,
   input  logic [NUM_REQS*WIDTH-1:0] flat_data_in,
   input  logic [WIDTH-1:0]         data_out,
   input  logic [TWID-1:0]          timeout_lim,
   output logic                     busy,
   output logic                     done,
   output logic                     prop_signal,
   output logic                     timeout,
   output logic [SELW-1:0]          tracked_sel,
   output logic [1:0]               dbg_state_o,
   output logic [PTRW-1:0]          dbg_pos_o,
   output logic [TWID-1:0]          dbg_wait_o,
   output logic [NUM_REQS*CNTW-1:0] dbg_cnt_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_TRACK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [SELW-1:0]     tsel_q, tsel_d;
   logic [WIDTH-1:0]    cap_q, cap_d;
   logic [PTRW-1:0]     pos_q, pos_d;
   logic [TWID-1:0]     wait_q, wait_d;
   logic                prop_q, prop_d;
   logic                tmo_q, tmo_d;
   logic [CNTW-1:0]     cnt_q [NUM_REQS];
   logic [CNTW-1:0]     cnt_d [NUM_REQS];

   logic [NUM_REQS-1:0] push_acc;
   logic [NUM_REQS-1:0] pop_acc;

   // Signals of the tracked channel, selected from the per-channel vectors
   logic                trk_push;
   logic                trk_pop;
   logic [WIDTH-1:0]    trk_data;
   logic [CNTW-1:0]     trk_cnt;

   logic                sel_ok;
   logic [TWID-1:0]     wait_inc;

   // ------------------------------------------------------------------------
   // Occupancy tracking. The pop decision is made first because a push into
   // a full channel is legal when a pop frees a slot in the same cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      pop_acc  = '0;
      push_acc = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         pop_acc[i]  = pop[i] && (cnt_q[i] != '0);
         push_acc[i] = push[i] && ((cnt_q[i] < CNTW'(DEPTH)) || pop_acc[i]);
         cnt_d[i]    = cnt_q[i] + CNTW'(push_acc[i]) - CNTW'(pop_acc[i]);
      end
   end

   always_comb begin
      trk_push = 1'b0;
      trk_pop  = 1'b0;
      trk_data = '0;
      trk_cnt  = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (tsel_q == SELW'(i)) begin
            trk_push = push_acc[i];
            trk_pop  = pop_acc[i];
            trk_data = flat_data_in[i*WIDTH +: WIDTH];
            trk_cnt  = cnt_q[i];
         end
      end
   end

   // SELW can encode values beyond NUM_REQS-1 when NUM_REQS is not a power
   // of two. Such a start is dropped.
   assign sel_ok = (int'(sel) < NUM_REQS);

   // The wait counter saturates instead of wrapping.
   assign wait_inc = (wait_q == '1) ? wait_q : (wait_q + TWID'(1));

   // ------------------------------------------------------------------------
   // Tracking FSM
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      tsel_d  = tsel_q;
      cap_d   = cap_q;
      pos_d   = pos_q;
      wait_d  = wait_q;
      prop_d  = prop_q;
      tmo_d   = tmo_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start && sel_ok) begin
               state_d = S_ARMED;
               tsel_d  = sel;
               prop_d  = 1'b1;
               tmo_d   = 1'b0;
            end
         end

         S_ARMED: begin
            if (trk_push) begin
               // A pop accepted in the same cycle removes an entry ahead of
               // the new item, so the item starts one place closer to the head.
               state_d = S_TRACK;
               cap_d   = trk_data;
               pos_d   = PTRW'(trk_cnt - CNTW'(trk_pop));
               wait_d  = '0;
            end
         end

         S_TRACK: begin
            if (trk_pop && (pos_q == '0)) begin
               // The completing pop wins over a timeout that expires in the same cycle.
               state_d = S_DONE;
               prop_d  = (data_out == cap_q);
            end else begin
               if (trk_pop) begin
                  pos_d = pos_q - PTRW'(1);
               end
               if (timeout_lim != '0) begin
                  wait_d = wait_inc;
                  if (wait_inc >= timeout_lim) begin
                     state_d = S_DONE;
                     tmo_d   = 1'b1;
                     prop_d  = 1'b0;
                  end
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         tsel_q  <= '0;
         cap_q   <= '0;
         pos_q   <= '0;
         wait_q  <= '0;
         prop_q  <= 1'b1;
         tmo_q   <= 1'b0;
         for (int i = 0; i < NUM_REQS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         tsel_q  <= tsel_d;
         cap_q   <= cap_d;
         pos_q   <= pos_d;
         wait_q  <= wait_d;
         prop_q  <= prop_d;
         tmo_q   <= tmo_d;
         for (int i = 0; i < NUM_REQS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign busy        = (state_q == S_ARMED) || (state_q == S_TRACK);
   assign done        = (state_q == S_DONE);
   assign prop_signal = prop_q;
   assign timeout     = tmo_q;
   assign tracked_sel = tsel_q;
   assign dbg_state_o = state_q;
   assign dbg_pos_o   = pos_q;
   assign dbg_wait_o  = wait_q;

   always_comb begin
      dbg_cnt_o = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         dbg_cnt_o[i*CNTW +: CNTW] = cnt_q[i];
      end
   end

endmodule

// File: tb/tb_arb_fifo_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_arb_fifo_scoreboard
//
// Directed bench for arb_fifo_scoreboard with NUM_REQS=4, WIDTH=8, DEPTH=4,
// TWID=8. A second instance with NUM_REQS=3 covers an out-of-range sel.
// Inputs change 1 time unit after a rising edge. Outputs are read at that
// same point, so each check sees the state written by the preceding edge.
// ---------------------------------------------------------------------------
module tb_arb_fifo_scoreboard;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_TRACK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT (NUM_REQS=4) ----------------
   logic        start = 1'b0;
   logic [1:0]  sel = '0;
   logic [3:0]  push = '0;
   logic [3:0]  pop = '0;
   logic [31:0] flat_data_in = '0;
   logic [7:0]  data_out = '0;
   logic [7:0]  timeout_lim = '0;
   logic        busy, done, prop_signal, timeout;
   logic [1:0]  tracked_sel, dbg_state;
   logic [1:0]  dbg_pos;
   logic [7:0]  dbg_wait;
   logic [11:0] dbg_cnt;

   arb_fifo_scoreboard #(.NUM_REQS(4), .WIDTH(8), .DEPTH(4), .TWID(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .sel(sel), .push(push), .pop(pop),
      .flat_data_in(flat_data_in), .data_out(data_out), .timeout_lim(timeout_lim),
      .busy(busy), .done(done), .prop_signal(prop_signal), .timeout(timeout),
      .tracked_sel(tracked_sel), .dbg_state_o(dbg_state), .dbg_pos_o(dbg_pos),
      .dbg_wait_o(dbg_wait), .dbg_cnt_o(dbg_cnt)
   );

   // ---------------- DUT (NUM_REQS=3) ----------------
   logic        start3 = 1'b0;
   logic [1:0]  sel3 = '0;
   logic [2:0]  push3 = '0;
   logic [2:0]  pop3 = '0;
   logic [23:0] flat3 = '0;
   logic [7:0]  dout3 = '0;
   logic [7:0]  lim3 = '0;
   logic        busy3, done3, prop3, tmo3;
   logic [1:0]  tsel3, state3, pos3;
   logic [7:0]  wait3;
   logic [8:0]  cnt3;

   arb_fifo_scoreboard #(.NUM_REQS(3), .WIDTH(8), .DEPTH(4), .TWID(8)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .sel(sel3), .push(push3), .pop(pop3),
      .flat_data_in(flat3), .data_out(dout3), .timeout_lim(lim3),
      .busy(busy3), .done(done3), .prop_signal(prop3), .timeout(tmo3),
      .tracked_sel(tsel3), .dbg_state_o(state3), .dbg_pos_o(pos3),
      .dbg_wait_o(wait3), .dbg_cnt_o(cnt3)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int ch, input logic [7:0] v);
      flat_data_in[ch*8 +: 8] = v;
   endtask

   function automatic logic [2:0] cnt_of(input int ch);
      return dbg_cnt[ch*3 +: 3];
   endfunction

   task automatic do_start(input logic [1:0] s);
      start = 1'b1;
      sel   = s;
      tick();
      start = 1'b0;
   endtask

   // ch1 preloaded with 3 entries, track 0x3C, 3 non-completing pops, then
   // a completing pop presenting cmp.
   task automatic run_pos(input logic [7:0] cmp, input logic exp_prop);
      push = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         set_data(1, 8'h10 + 8'(k));
         tick();
      end
      push = '0;
      chk("pos_preload_cnt1", cnt_of(1), 3);
      do_start(2'd1);
      chk("pos_armed", dbg_state, S_ARMED);
      chk("pos_armed_prop", prop_signal, 1);
      push = 4'b0010;
      set_data(1, 8'h3C);
      tick();
      push = '0;
      chk("pos_track", dbg_state, S_TRACK);
      chk("pos_init", dbg_pos, 3);
      chk("pos_cnt1_4", cnt_of(1), 4);
      for (int k = 0; k < 3; k++) begin
         pop      = 4'b0010;
         data_out = 8'h10 + 8'(k);
         tick();
         chk("pos_pop_state", dbg_state, S_TRACK);
         chk("pos_pop_pos", dbg_pos, 32'(2 - k));
      end
      pop      = 4'b0010;
      data_out = cmp;
      tick();
      pop = '0;
      chk("pos_done", done, 1);
      chk("pos_prop", prop_signal, exp_prop);
      chk("pos_tmo", timeout, 0);
      chk("pos_cnt1_0", cnt_of(1), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_state", dbg_state, S_IDLE);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_prop", prop_signal, 1);
      chk("rst_tmo", timeout, 0);
      chk("rst_tsel", tracked_sel, 0);
      chk("rst_cnt", dbg_cnt, 0);
      chk("rst_busy3", busy3, 0);
      rst = 1'b1;

      // Empty channel, sel=2
      do_start(2'd2);
      chk("a_armed", dbg_state, S_ARMED);
      chk("a_busy", busy, 1);
      chk("a_tsel", tracked_sel, 2);
      push = 4'b0100;
      set_data(2, 8'hA5);
      tick();
      chk("a_track", dbg_state, S_TRACK);
      chk("a_pos", dbg_pos, 0);
      chk("a_cnt2", cnt_of(2), 1);
      // Untracked traffic: push ch3, pop empty ch0 (ignored)
      push = 4'b1000;
      pop  = 4'b0001;
      set_data(3, 8'h66);
      tick();
      push = '0;
      pop  = '0;
      chk("a_cnt3", cnt_of(3), 1);
      chk("a_cnt0_empty_pop", cnt_of(0), 0);
      chk("a_still_track", dbg_state, S_TRACK);
      tick();
      chk("a_no_tmo_lim0", dbg_state, S_TRACK);
      pop      = 4'b0100;
      data_out = 8'hA5;
      tick();
      pop = '0;
      chk("a_done", done, 1);
      chk("a_prop", prop_signal, 1);
      chk("a_busy_off", busy, 0);
      chk("a_cnt2_0", cnt_of(2), 0);

      // Position tracking, match then mismatch
      run_pos(8'h3C, 1'b1);
      run_pos(8'h3D, 1'b0);
      tick();
      chk("pos_sticky_prop", prop_signal, 0);
      chk("pos_sticky_done", done, 1);

      // Full channel
      push = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         set_data(0, 8'h40 + 8'(k));
         tick();
      end
      set_data(0, 8'hEE);
      tick();
      push = '0;
      chk("c_full_cnt0", cnt_of(0), 4);
      do_start(2'd0);
      chk("c_armed", dbg_state, S_ARMED);
      chk("c_prop_cleared", prop_signal, 1);
      push = 4'b0001;
      set_data(0, 8'h77);
      tick();
      chk("c_reject_state", dbg_state, S_ARMED);
      chk("c_reject_cnt0", cnt_of(0), 4);
      pop      = 4'b0001;
      data_out = 8'h40;
      tick();
      push = '0;
      pop  = '0;
      chk("c_capture", dbg_state, S_TRACK);
      chk("c_pos3", dbg_pos, 3);
      chk("c_cnt0", cnt_of(0), 4);
      pop = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         data_out = 8'h41 + 8'(k);
         tick();
      end
      chk("c_before_head", dbg_state, S_TRACK);
      data_out = 8'h77;
      tick();
      pop = '0;
      chk("c_done", done, 1);
      chk("c_prop", prop_signal, 1);
      chk("c_cnt0_0", cnt_of(0), 0);

      // Timeout after 5 TRACK cycles
      timeout_lim = 8'd5;
      do_start(2'd3);
      push = 4'b1000;
      set_data(3, 8'h5A);
      tick();
      push = '0;
      chk("d_track", dbg_state, S_TRACK);
      chk("d_pos1", dbg_pos, 1);
      chk("d_wait0", dbg_wait, 0);
      chk("d_cnt3", cnt_of(3), 2);
      repeat (4) tick();
      chk("d_track_4", dbg_state, S_TRACK);
      chk("d_wait4", dbg_wait, 4);
      tick();
      chk("d_tmo_state", dbg_state, S_DONE);
      chk("d_tmo", timeout, 1);
      chk("d_tmo_prop", prop_signal, 0);
      tick();
      chk("d_tmo_sticky", timeout, 1);
      pop = 4'b1000;
      tick();
      tick();
      pop = '0;
      chk("d_drain_cnt3", cnt_of(3), 0);
      // Completing pop on the expiry cycle wins
      do_start(2'd3);
      chk("d2_clear_tmo", timeout, 0);
      push = 4'b1000;
      set_data(3, 8'hC3);
      tick();
      push = '0;
      chk("d2_pos0", dbg_pos, 0);
      repeat (4) tick();
      chk("d2_track_4", dbg_state, S_TRACK);
      pop      = 4'b1000;
      data_out = 8'hC3;
      tick();
      pop = '0;
      chk("d2_done", dbg_state, S_DONE);
      chk("d2_no_tmo", timeout, 0);
      chk("d2_prop", prop_signal, 1);

      // Reset in TRACK, start ignored while busy, reset beats start
      timeout_lim = 8'd0;
      do_start(2'd1);
      chk("e_armed", dbg_state, S_ARMED);
      do_start(2'd3);
      chk("e_start_ignored", tracked_sel, 1);
      push = 4'b0011;
      set_data(1, 8'h99);
      set_data(0, 8'h01);
      tick();
      push = '0;
      chk("e_track", dbg_state, S_TRACK);
      rst   = 1'b0;
      start = 1'b1;
      sel   = 2'd2;
      tick();
      rst   = 1'b1;
      start = 1'b0;
      chk("e_rst_state", dbg_state, S_IDLE);
      chk("e_rst_busy", busy, 0);
      chk("e_rst_prop", prop_signal, 1);
      chk("e_rst_tsel", tracked_sel, 0);
      chk("e_rst_cnt", dbg_cnt, 0);
      chk("e_rst_pos", dbg_pos, 0);
      do_start(2'd2);
      chk("e_rearm", dbg_state, S_ARMED);
      chk("e_rearm_tsel", tracked_sel, 2);

      // Out-of-range sel on the 3-channel instance
      start3 = 1'b1;
      sel3   = 2'd3;
      tick();
      start3 = 1'b0;
      chk("f_bad_sel_state", state3, S_IDLE);
      chk("f_bad_sel_busy", busy3, 0);
      chk("f_bad_sel_tsel", tsel3, 0);
      start3 = 1'b1;
      sel3   = 2'd1;
      tick();
      start3 = 1'b0;
      chk("f_good_sel_busy", busy3, 1);
      chk("f_good_sel_tsel", tsel3, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/arb_fifo_scoreboard.md
ARB_FIFO_SCOREBOARD -- requirements
Module: arb_fifo_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of monitored FIFO channels (>=2).
REQ-002 SHALL have parameter WIDTH, default 8: data width per channel.
REQ-003 SHALL have parameter DEPTH, default 8: capacity of each monitored FIFO.
REQ-004 SHALL have parameter TWID, default 8: timeout counter and limit width.
REQ-005 SHALL derive local SELW = max(1, clog2(NUM_REQS)), CNTW = clog2(DEPTH+1), PTRW = max(1, clog2(DEPTH)).
REQ-006 SHALL have clk  in  1: single clock; all state updates on its rising edge.
REQ-007 SHALL have rst  in  1: synchronous, active-low reset.
REQ-008 SHALL have start  in  1: arm request.
REQ-009 SHALL have sel  in  SELW: channel to track, sampled on accepted start.
REQ-010 SHALL have push  in  NUM_REQS: per-channel push strobes.
REQ-011 SHALL have pop  in  NUM_REQS: per-channel pop strobes (arbiter grants).
REQ-012 SHALL have flat_data_in  in  NUM_REQS*WIDTH: channel i occupies bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-013 SHALL have data_out  in  WIDTH: shared FIFO output; valid in any cycle with a pop.
REQ-014 SHALL have timeout_lim  in  TWID: max cycles in TRACK; 0 disables timeout.
REQ-015 SHALL have busy  out  1: high in ARMED or TRACK.
REQ-016 SHALL have done  out  1: high in DONE.
REQ-017 SHALL have prop_signal  out  1: low only on detected failure.
REQ-018 SHALL have timeout  out  1: high when the failure was a timeout.
REQ-019 SHALL have tracked_sel  out  SELW: latched channel.

Function
REQ-020 SHALL keep a CNTW-bit occupancy count per channel: accepted push +1, accepted pop -1, both 0.
REQ-021 SHALL accept a push only if count<DEPTH or a pop is accepted on the same channel in the same cycle.
REQ-022 SHALL accept a pop only if count>0; a pop on an empty channel is ignored.
REQ-023 SHALL implement states IDLE, ARMED, TRACK, DONE.
REQ-024 In IDLE or DONE, start SHALL latch sel into tracked_sel, clear prop failure/timeout, and move to ARMED next cycle.
REQ-025 SHALL ignore start in ARMED and TRACK.
REQ-026 SHALL treat sel >= NUM_REQS on start as ignored; state is unchanged.
REQ-027 In ARMED, an accepted push on tracked_sel SHALL capture that channel's data, set pos = count - (accepted pop ? 1 : 0), clear the wait counter, and enter TRACK.
REQ-028 In ARMED, a rejected (full) push SHALL not be captured; state remains ARMED.
REQ-029 In TRACK, an accepted pop on tracked_sel with pos>0 SHALL decrement pos.
REQ-030 In TRACK, an accepted pop with pos==0 SHALL compare data_out with captured data in the same cycle and enter DONE; on mismatch prop_signal drops next cycle.
REQ-031 In TRACK with timeout_lim!=0, the wait counter SHALL increment each cycle without a completing pop.
REQ-032 On reaching timeout_lim, the block SHALL enter DONE with timeout=1 and prop_signal=0.
REQ-033 A completing pop in the same cycle as limit expiry SHALL take priority; no timeout is flagged.
REQ-034 The wait counter SHALL saturate; it SHALL not wrap.
REQ-035 prop_signal and timeout SHALL stay sticky in DONE until the next accepted start or reset.
REQ-036 Pushes and pops on untracked channels SHALL affect only their counts.

Reset
REQ-037 With rst=0 at a clk edge: state=IDLE; all counts, pos and the wait counter=0; busy=0, done=0, prop_signal=1, timeout=0, tracked_sel=0.
REQ-038 Reset mid-operation SHALL abort tracking and discard captured data; reset SHALL override start.

Verification (NUM_REQS=4, WIDTH=8, DEPTH=4, TWID=8)
REQ-039 Empty channel: start with sel=2; push[2]=0xA5; 3 cycles later pop[2] with data_out=0xA5 -> done=1, prop_signal=1.
REQ-040 Position: ch1 preloaded with 3 entries; track push 0x3C; 3 pops do not complete; 4th pop with data_out=0x3C -> pass; repeating with data_out=0x3D -> prop_signal=0.
REQ-041 Full: ch0 count=4; push[0] while ARMED with no pop -> stays ARMED, count stays 4. Same with pop[0] asserted -> capture, pos=3.
REQ-042 Timeout: timeout_lim=5; track push, no pops -> DONE after 5 TRACK cycles, timeout=1, prop_signal=0. Pop arriving on the 5th cycle -> no timeout.
REQ-043 Reset in TRACK with rst=0 for 1 cycle -> busy=0, prop_signal=1, counts=0; subsequent start re-arms.
REQ-044 Invalid sel=5 (SELW=2 cannot encode it); use NUM_REQS=3, sel=3 -> remains IDLE, busy=0.
